// File: rtl/array_divider_seq.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Optional macro ARRAY_DIVIDER_DIVZERO_EN: zero divisor short-circuits to DONE and raises div_by_zero.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on accept
// S_RUN  | one restoring iteration per clock, 2N clocks total
// S_DONE | results valid, done pulse, returns to idle next clock
module array_divider_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(2 * N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2*N-1:0] r_dvd;
  logic [N-1:0]   r_dsr;
  logic [N-1:0]   r_rem;
  logic [2*N-1:0] r_quot;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_quot_out;
  logic [N-1:0]   r_rem_out;

  logic           w_accept;
  logic           w_fast;
  logic           w_last;
  logic [N:0]     w_shift;
  logic [N-1:0]   w_diff;
  logic           w_qbit;
  logic [N-1:0]   w_rem_nxt;
  logic [2*N-1:0] w_quot_nxt;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == '0);

`ifdef ARRAY_DIVIDER_DIVZERO_EN
  logic r_dz;
  assign w_fast      = w_accept && (divisor == '0);
  assign div_by_zero = r_dz;
`else
  assign w_fast      = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  // The restored remainder is always below the divisor, so N bits suffice between
  // iterations; a compare on the N+1 bit shifted value replaces the sign test.
  assign w_shift    = {r_rem, r_dvd[2*N-1]};
  assign w_qbit     = (w_shift >= {1'b0, r_dsr});
  assign w_diff     = w_shift[N-1:0] - r_dsr;
  assign w_rem_nxt  = w_qbit ? w_diff : w_shift[N-1:0];
  assign w_quot_nxt = {r_quot[2*N-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_fast ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_dvd  <= dividend;
      r_dsr  <= divisor;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= CW'(2 * N - 1);
    end else if (r_state == S_RUN) begin
      r_dvd  <= {r_dvd[2*N-2:0], 1'b0};
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quot_out <= '0;
      r_rem_out  <= '0;
`ifdef ARRAY_DIVIDER_DIVZERO_EN
      r_dz       <= 1'b0;
`endif
    end else if (w_last) begin
      r_quot_out <= w_quot_nxt;
      r_rem_out  <= w_rem_nxt;
`ifdef ARRAY_DIVIDER_DIVZERO_EN
      r_dz       <= 1'b0;
`endif
    end else if (w_fast) begin
      r_quot_out <= '1;
      r_rem_out  <= dividend[N-1:0];
`ifdef ARRAY_DIVIDER_DIVZERO_EN
      r_dz       <= 1'b1;
`endif
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quot_out;
  assign remainder = r_rem_out;

endmodule

// File: tb/tb_array_divider_seq.sv
// Directed bench for array_divider_seq at N=4 with hand-computed quotients and remainders.
module tb_array_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks;
  int n_fail;

  array_divider_seq #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARRAY_DIVIDER_DIVZERO_EN
  localparam int EXP_DZ_LAT = 0;
  localparam logic EXP_DZ = 1'b1;
`else
  localparam int EXP_DZ_LAT = 8;
  localparam logic EXP_DZ = 1'b0;
`endif

  // Issues one start from IDLE; lat counts clock edges after the accepting edge until done is seen.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r, output logic dz,
                        output int lat, output int bcnt, output int ovl, output logic nd);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = 8'h5A; divisor = 4'h3;
    lat = -1; bcnt = 0; ovl = 0; q = 'x; r = 'x; dz = 'x; nd = 1'bx;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (busy && done) ovl++;
      if (done) begin
        lat = i; q = quotient; r = remainder; dz = div_by_zero;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    nd = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q; logic [3:0] r; logic dz, nd; int lat, bcnt, ovl;
    run_op(8'd200, 4'd7, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if (q !== 8'd28) begin n_fail++; $display("FAIL basic_q: got %0d want 28", q); end
    n_checks++;
    if (r !== 4'd4) begin n_fail++; $display("FAIL basic_r: got %0d want 4", r); end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_checks++;
    if (bcnt !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bcnt); end
    n_checks++;
    if (ovl !== 0) begin n_fail++; $display("FAIL basic_busy_done_overlap: got %0d want 0", ovl); end
    n_checks++;
    if (nd !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse_width: done after pulse %b want 0", nd); end
    n_checks++;
    if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", dz); end
  endtask

  task automatic test_edges();
    logic [7:0] q; logic [3:0] r; logic dz, nd; int lat, bcnt, ovl;
    run_op(8'd255, 4'd1, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r} !== {8'd255, 4'd0}) begin
      n_fail++; $display("FAIL div_255_1: got q=%0d r=%0d want q=255 r=0", q, r);
    end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL div_255_1_latency: got %0d want 8", lat); end
    run_op(8'd0, 4'd15, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r} !== {8'd0, 4'd0}) begin
      n_fail++; $display("FAIL div_0_15: got q=%0d r=%0d want q=0 r=0", q, r);
    end
    run_op(8'd143, 4'd11, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r} !== {8'd13, 4'd0}) begin
      n_fail++; $display("FAIL div_143_11: got q=%0d r=%0d want q=13 r=0", q, r);
    end
    run_op(8'd254, 4'd15, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r} !== {8'd16, 4'd14}) begin
      n_fail++; $display("FAIL div_254_15: got q=%0d r=%0d want q=16 r=14", q, r);
    end
  endtask

  task automatic test_divzero();
    logic [7:0] q; logic [3:0] r; logic dz, nd; int lat, bcnt, ovl;
    run_op(8'd13, 4'd0, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r} !== {8'd255, 4'd13}) begin
      n_fail++; $display("FAIL divzero_result: got q=%0d r=%0d want q=255 r=13", q, r);
    end
    n_checks++;
    if (dz !== EXP_DZ) begin n_fail++; $display("FAIL divzero_flag: got %b want %b", dz, EXP_DZ); end
    n_checks++;
    if (lat !== EXP_DZ_LAT) begin
      n_fail++; $display("FAIL divzero_latency: got %0d want %0d", lat, EXP_DZ_LAT);
    end
    run_op(8'd9, 4'd3, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r, dz} !== {8'd3, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL divzero_clear: got q=%0d r=%0d dz=%b want q=3 r=0 dz=0", q, r, dz);
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [7:0] q; logic [3:0] r;
    ndone = 0; q = '0; r = '0;
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      if (t == 2 || t == 5) begin start = 1'b1; dividend = 8'd50; divisor = 4'd2; end
      else start = 1'b0;
      if (done) begin ndone++; q = quotient; r = remainder; end
      @(posedge clk);
      #1 start = 1'b0;
    end
    n_checks++;
    if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    n_checks++;
    if ({q, r} !== {8'd28, 4'd4}) begin
      n_fail++; $display("FAIL ignore_result: got q=%0d r=%0d want q=28 r=4", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int n, tdone[2];
    logic [7:0] qv[2]; logic [3:0] rv[2];
    int t;
    n = 0; t = 0;
    tdone[0] = -1; tdone[1] = -1; qv[0] = 'x; qv[1] = 'x; rv[0] = 'x; rv[1] = 'x;
    @(negedge clk);
    dividend = 8'd40; divisor = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 dividend = 8'd225; divisor = 4'd15;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (done && n < 2) begin tdone[n] = t; qv[n] = quotient; rv[n] = remainder; n++; end
      @(posedge clk);
      t++;
      if (t == 10) #1 start = 1'b0;
    end
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n); end
    n_checks++;
    if ({qv[0], rv[0]} !== {8'd8, 4'd0}) begin
      n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d want q=8 r=0", qv[0], rv[0]);
    end
    n_checks++;
    if ({qv[1], rv[1]} !== {8'd15, 4'd0}) begin
      n_fail++; $display("FAIL b2b_second: got q=%0d r=%0d want q=15 r=0", qv[1], rv[1]);
    end
    n_checks++;
    if (tdone[1] - tdone[0] !== 10) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want 10", tdone[1] - tdone[0]);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    logic [7:0] q; logic [3:0] r; logic dz, nd; int lat, bcnt, ovl;
    ndone = 0;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    run_op(8'd100, 4'd3, q, r, dz, lat, bcnt, ovl, nd);
    n_checks++;
    if ({q, r} !== {8'd33, 4'd1}) begin
      n_fail++; $display("FAIL abort_restart: got q=%0d r=%0d want q=33 r=1", q, r);
    end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL abort_restart_latency: got %0d want 8", lat); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_edges();
    test_divzero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
